mac_operand_sequencer: RTL and testbench
========================================

Name: mac_operand_sequencer

Overview:
- Initiator for the MAC accumulator interface. It drives the operand A, operand B, SCLR and LOAD inputs and reads back MAC_OUT.
- Host preloads up to DEPTH operand pairs, then pulses START. The block clears the accumulator, streams LEN pairs with LOAD, captures the final MAC_OUT into RESULT and pulses DONE.
- Sits between the control host and one MAC instance, in the same SYS_CLK domain.

Parameters:
- IN1_WIDTH, 3, operand A width; matches MAC
- IN2_WIDTH, 3, operand B width; matches MAC
- OUT_WIDTH, 6, accumulator width; matches MAC
- DEPTH, 8, operand-pair storage entries (power of 2)
- LEN_WIDTH, 4, width of LEN; must hold DEPTH

Ports:
- SYS_CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- WR_EN  in  1  write one operand pair
- WR_ADDR  in  log2(DEPTH)  write entry index
- WR_A  in  IN1_WIDTH  operand A write data
- WR_B  in  IN2_WIDTH  operand B write data
- LEN  in  LEN_WIDTH  number of pairs to accumulate; sampled with START
- START  in  1  begin sequence; honoured only in IDLE
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- RESULT  out  OUT_WIDTH  captured accumulator value
- OVF  out  1  overflow flag (see Optional Feature)
- MAC_A  out  IN1_WIDTH  to MAC operand A
- MAC_B  out  IN2_WIDTH  to MAC operand B
- MAC_SCLR  out  1  to MAC SCLR
- MAC_LOAD  out  1  to MAC LOAD
- MAC_OUT  in  OUT_WIDTH  from MAC accumulator

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, index=0.
  - BUSY, DONE, RESULT, OVF, MAC_SCLR, MAC_LOAD all 0.
  - Operand storage cleared to 0.
- Storage write:
  - WR_EN=1 in IDLE writes WR_A/WR_B to entry WR_ADDR at the clock edge.
  - WR_EN ignored whenever BUSY=1.
- START in IDLE, sampled at edge t0:
  - Latch len_q = min(LEN, DEPTH).
  - Go to CLEAR.
  - START while BUSY is ignored.
- CLEAR (1 cycle): MAC_SCLR=1, MAC_LOAD=0. Next state FEED, or CAPTURE if len_q=0.
- FEED (len_q cycles):
  - MAC_LOAD=1; MAC_A/MAC_B = storage[index], combinational from index.
  - index increments each cycle. After the cycle with index=len_q-1, go to CAPTURE and reset index to 0.
- CAPTURE (1 cycle):
  - MAC_OUT now holds the full sum.
  - At the edge: RESULT<=MAC_OUT, DONE<=1, state<=IDLE.
- Outside FEED: MAC_A=0, MAC_B=0, MAC_LOAD=0. MAC_SCLR is high only in CLEAR.
- Timing:
  - DONE is high for exactly the one cycle following edge t0+len_q+2.
  - BUSY is high from edge t0 until that same edge.
  - A new START is accepted in the cycle DONE is high (state is IDLE).
- RESULT holds its value until the next CAPTURE or reset. It is not cleared by START.
- Arithmetic: modulo 2^OUT_WIDTH, performed by the MAC. The sequencer passes MAC_OUT through unmodified.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. Storage is cleared too, so the host must rewrite operands.

Optional Feature:
- Macro: MAC_SEQ_OVF_CHECK_EN
- Defined:
  - A shadow accumulator of width OUT_WIDTH+LEN_WIDTH clears in CLEAR and adds MAC_A*MAC_B in each FEED cycle.
  - At CAPTURE, OVF<=1 if the shadow value exceeds 2^OUT_WIDTH-1, else 0.
  - OVF is valid alongside DONE and held like RESULT. Reset clears it.
- Not defined: no shadow logic; OVF is tied to 0.

Test Plan:
- Write A={1,2,3}, B={4,5,6} at entries 0-2; START with LEN=3 -> one MAC_SCLR cycle, then 3 MAC_LOAD cycles; DONE 5 cycles after the START edge; RESULT=32; OVF=0.
- LEN=0 -> SCLR cycle then CAPTURE; DONE 2 cycles after START; RESULT=0.
- A={7,7}, B={7,7}, LEN=2 -> RESULT=34 (98 mod 64); OVF=1 with the macro defined, 0 without.
- LEN=12 with all 8 entries written as A=1, B=1 -> clamped to 8 FEED cycles; RESULT=8; DONE 10 cycles after START.
- START and WR_EN pulsed during FEED -> both ignored; RESULT and storage unaffected; a second START on the DONE cycle is accepted.
- RST_N driven low for 1 cycle during FEED -> BUSY, MAC_LOAD and DONE drop immediately; RESULT=0; storage reads 0; next START with LEN=3 gives RESULT=0.

Source files
------------

// File: rtl/mac_operand_sequencer_if.sv
// Bundle of host-side and MAC-side signals for mac_operand_sequencer.
// The host/MAC environment uses the master modport. The sequencer uses the slave modport.
interface mac_operand_sequencer_if #(
    parameter int IN1_WIDTH = 3,
    parameter int IN2_WIDTH = 3,
    parameter int OUT_WIDTH = 6,
    parameter int DEPTH     = 8,
    parameter int LEN_WIDTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // host side
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [IN1_WIDTH-1:0] wr_a;
    logic [IN2_WIDTH-1:0] wr_b;
    logic [LEN_WIDTH-1:0] len;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [OUT_WIDTH-1:0] result;
    logic                 ovf;

    // MAC side
    logic [IN1_WIDTH-1:0] mac_a;
    logic [IN2_WIDTH-1:0] mac_b;
    logic                 mac_sclr;
    logic                 mac_load;
    logic [OUT_WIDTH-1:0] mac_out;

    modport master (
        output wr_en, wr_addr, wr_a, wr_b, len, start, mac_out,
        input  busy, done, result, ovf, mac_a, mac_b, mac_sclr, mac_load
    );

    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, len, start, mac_out,
        output busy, done, result, ovf, mac_a, mac_b, mac_sclr, mac_load
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: preloads operand pairs, then clears a MAC accumulator,
// streams LEN pairs into it and captures the final sum into RESULT with a DONE pulse.
// Optional macro MAC_SEQ_OVF_CHECK_EN: adds a wide shadow accumulator that flags
// overflow of the MAC's modulo-2^OUT_WIDTH sum on OVF. Without it OVF is tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for START; operand storage writable
// CLEAR   | one cycle of MAC_SCLR to zero the accumulator
// FEED    | len_q cycles of MAC_LOAD, operands from storage[index]
// CAPTURE | MAC_OUT holds the full sum; latch RESULT, pulse DONE
module mac_operand_sequencer #(
    parameter int IN1_WIDTH = 3,
    parameter int IN2_WIDTH = 3,
    parameter int OUT_WIDTH = 6,
    parameter int DEPTH     = 8,
    parameter int LEN_WIDTH = 4
) (
    input  logic                   sys_clk_i,
    input  logic                   rst_n_i,
    mac_operand_sequencer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_FEED    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t               state_q;
    logic [AW-1:0]        index_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 sclr_q;
    logic                 load_q;
    logic [OUT_WIDTH-1:0] result_q;
    logic                 last_feed;

    logic [IN1_WIDTH-1:0] mem_a_q [DEPTH];
    logic [IN2_WIDTH-1:0] mem_b_q [DEPTH];

    // Requests longer than the storage are clamped to the full storage.
    assign len_d     = (bus.len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : bus.len;
    assign last_feed = (LEN_WIDTH'(index_q) == (len_q - LEN_WIDTH'(1)));

    // Sequencer FSM with registered control outputs.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            len_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclr_q   <= 1'b0;
            load_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        len_q   <= len_d;
                        busy_q  <= 1'b1;
                        sclr_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    sclr_q <= 1'b0;
                    if (len_q == '0) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        load_q  <= 1'b1;
                        state_q <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (last_feed) begin
                        index_q <= '0;
                        load_q  <= 1'b0;
                        state_q <= ST_CAPTURE;
                    end else begin
                        index_q <= index_q + AW'(1);
                    end
                end
                ST_CAPTURE: begin
                    result_q <= bus.mac_out;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    sclr_q  <= 1'b0;
                    load_q  <= 1'b0;
                    index_q <= '0;
                end
            endcase
        end
    end

    // Operand storage; writable only while idle, cleared by reset.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else if (bus.wr_en && (state_q == ST_IDLE)) begin
            mem_a_q[bus.wr_addr] <= bus.wr_a;
            mem_b_q[bus.wr_addr] <= bus.wr_b;
        end
    end

    // Operands are presented combinationally from index and held at 0 outside FEED.
    assign bus.mac_a    = load_q ? mem_a_q[index_q] : '0;
    assign bus.mac_b    = load_q ? mem_b_q[index_q] : '0;
    assign bus.mac_sclr = sclr_q;
    assign bus.mac_load = load_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;

`ifdef MAC_SEQ_OVF_CHECK_EN
    localparam int SW = OUT_WIDTH + LEN_WIDTH;
    localparam int PW = IN1_WIDTH + IN2_WIDTH;

    logic [SW-1:0] shadow_q;
    logic [PW-1:0] prod;
    logic          ovf_q;

    assign prod = PW'(bus.mac_a) * PW'(bus.mac_b);

    // Shadow accumulator mirrors the MAC without wrap; any bit above OUT_WIDTH means overflow.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR:   shadow_q <= '0;
                ST_FEED:    shadow_q <= shadow_q + SW'(prod);
                ST_CAPTURE: ovf_q    <= |shadow_q[SW-1:OUT_WIDTH];
                default:    shadow_q <= shadow_q;
            endcase
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Scoreboard bench for mac_operand_sequencer with a behavioural MAC attached.
module tb_mac_operand_sequencer;
`ifdef MAC_SEQ_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        int res;
        int ovf;
        int done_cyc;
        int nload;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   sclr_cnt = 0;
    int   load_cnt = 0;
    exp_t sb[$];
    logic [5:0] mac_acc;

    mac_operand_sequencer_if bus ();

    mac_operand_sequencer dut (
        .sys_clk_i (clk),
        .rst_n_i   (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural MAC: SCLR clears, LOAD adds A*B modulo 64
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            mac_acc <= '0;
        else if (bus.mac_sclr) mac_acc <= '0;
        else if (bus.mac_load) mac_acc <= mac_acc + (6'(bus.mac_a) * 6'(bus.mac_b));
    end
    assign bus.mac_out = mac_acc;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: counts MAC control cycles and checks each DONE against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sclr_cnt = 0;
            load_cnt = 0;
        end else begin
            if (bus.mac_sclr) sclr_cnt++;
            if (bus.mac_load) load_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result",       int'(bus.result), e.res);
                    chk("ovf",          int'(bus.ovf),    e.ovf);
                    chk("done_latency", cyc,              e.done_cyc);
                    chk("sclr_cycles",  sclr_cnt,         1);
                    chk("load_cycles",  load_cnt,         e.nload);
                    chk("busy_at_done", int'(bus.busy),   0);
                end
                sclr_cnt = 0;
                load_cnt = 0;
            end
        end
    end

    // called at a negedge; leaves at the following negedge
    task automatic wr(input int addr, input int a, input int b);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(addr);
        bus.wr_a    = 3'(a);
        bus.wr_b    = 3'(b);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // called at a negedge; issues START and pushes the expected completion
    task automatic start_seq(input int len, input int res, input int ovf);
        exp_t e;
        int   leff;
        leff       = (len > 8) ? 8 : len;
        e.res      = res;
        e.ovf      = ovf;
        e.done_cyc = cyc + 1 + leff + 2;
        e.nload    = leff;
        sb.push_back(e);
        bus.len   = 4'(len);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("sclr_in_clear",    int'(bus.mac_sclr), 1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("done_timeout_pending", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_a    = '0;
        bus.wr_b    = '0;
        bus.len     = '0;
        bus.start   = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy",   int'(bus.busy),     0);
        chk("rst_done",   int'(bus.done),     0);
        chk("rst_result", int'(bus.result),   0);
        chk("rst_ovf",    int'(bus.ovf),      0);
        chk("rst_sclr",   int'(bus.mac_sclr), 0);
        chk("rst_load",   int'(bus.mac_load), 0);
        chk("rst_mac_a",  int'(bus.mac_a),    0);
        chk("rst_mac_b",  int'(bus.mac_b),    0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1*4 + 2*5 + 3*6 = 32
        wr(0, 1, 4);
        wr(1, 2, 5);
        wr(2, 3, 6);
        start_seq(3, 32, 0);
        wait_empty();

        // zero length: SCLR then capture of the cleared accumulator
        start_seq(0, 0, 0);
        wait_empty();

        // 7*7 + 7*7 = 98 -> 34 modulo 64
        wr(0, 7, 7);
        wr(1, 7, 7);
        start_seq(2, 34, int'(OVF_EN));
        wait_empty();

        // LEN=12 clamps to 8
        for (int i = 0; i < 8; i++) wr(i, 1, 1);
        start_seq(12, 8, 0);
        wait_empty();

        // START and WR_EN during FEED are ignored; restart on the DONE cycle
        start_seq(8, 8, 0);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len     = 4'd3;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_a    = 3'd7;
        bus.wr_b    = 3'd7;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.wr_en   = 1'b0;
        begin
            int guard = 0;
            while (!bus.done && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            chk("done_seen_for_restart", int'(bus.done), 1);
        end
        start_seq(8, 8, 0);
        wait_empty();

        // reset during FEED
        start_seq(3, 3, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",   int'(bus.busy),     0);
        chk("midrst_load",   int'(bus.mac_load), 0);
        chk("midrst_done",   int'(bus.done),     0);
        chk("midrst_result", int'(bus.result),   0);
        chk("midrst_ovf",    int'(bus.ovf),      0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start_seq(3, 0, 0);
        wait_empty();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
